// File: rtl/inject_unit_pkg.sv
// Shared field layout, op encodings and defaults for the injection unit.
package inject_unit_pkg;

  // Router-wide sizing.
  localparam int unsigned MaxVc         = 4;
  localparam int unsigned VcBitSize     = 2;

  // Flit layout: {dst, head, tail, payload}.
  localparam int unsigned FlitBitSize   = 16;
  localparam int unsigned FlitDstMsb    = 15;
  localparam int unsigned FlitDstLsb    = 12;
  localparam int unsigned FlitHead      = 11;
  localparam int unsigned FlitTail      = 10;

  // Staging word layout: {full, vc, flit}.
  localparam int unsigned BufferBitSize = 1 + VcBitSize + FlitBitSize;
  localparam int unsigned BufferFull    = BufferBitSize - 1;
  localparam int unsigned BufferVcMsb   = BufferBitSize - 2;
  localparam int unsigned BufferVcLsb   = FlitBitSize;

  // Injection unit defaults.
  localparam int unsigned InjDepth      = 8;
  localparam int unsigned InjCntBitSize = 32;

  // Router op bus encodings.
  typedef enum logic [2:0] {
    OpNop         = 3'd0,
    OpPhase0      = 3'd1,
    OpPhase1      = 3'd2,
    OpLoadRt      = 3'd3,
    OpLoadStaging = 3'd4,
    OpInit        = 3'd5
  } op_e;

  typedef logic [FlitBitSize-1:0] flit_t;

  typedef struct packed {
    logic                 full;
    logic [VcBitSize-1:0] vc;
    flit_t                flit;
  } staging_t;

endpackage

// File: rtl/inject_unit_if.sv
// Host enqueue handshake plus router-facing op/back-pressure/staging signals.
interface inject_unit_if
  import inject_unit_pkg::*;
#(
  parameter int unsigned NumVc = MaxVc,
  parameter int unsigned CntW  = InjCntBitSize
);

  op_e                  op;
  logic [NumVc-1:0]     can_inject;
  logic                 enq_valid;
  logic [VcBitSize-1:0] enq_vc;
  flit_t                enq_flit;
  logic [NumVc-1:0]     enq_ready;
  staging_t             inj_staging;
  logic                 idle;
  logic [CntW-1:0]      flits_sent;

  // Host/testbench side.
  modport master (
    output op, can_inject, enq_valid, enq_vc, enq_flit,
    input  enq_ready, inj_staging, idle, flits_sent
  );

  // Injection unit side.
  modport slave (
    input  op, can_inject, enq_valid, enq_vc, enq_flit,
    output enq_ready, inj_staging, idle, flits_sent
  );

endinterface

// File: rtl/inj_fifo.sv
// Single-VC synchronous FIFO: wrapping binary pointers plus an occupancy count.
module inj_fifo
  import inject_unit_pkg::*;
#(
  parameter int unsigned Depth = InjDepth
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  flit_t wdata_i,
  input  logic  pop_i,
  output flit_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  flit_t           mem [Depth];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  // Full/empty come from the pre-edge count, so a full FIFO refuses a push even while popping.
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_q];

  // Pointer and count next-state; Depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q + PtrW'(do_push);
    rd_d  = rd_q + PtrW'(do_pop);
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer/count state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/inject_unit.sv
// Injection stage feeding router local port 0: per-VC FIFOs, round-robin pick on
// LoadStaging, one-cycle staging word that is cleared on every other op.
module inject_unit
  import inject_unit_pkg::*;
#(
  parameter int unsigned NumVc = MaxVc,
  parameter int unsigned Depth = InjDepth,
  parameter int unsigned CntW  = InjCntBitSize
) (
  input logic          clk,
  input logic          rst_n,
  inject_unit_if.slave bus
);

  logic [NumVc-1:0]     push, pop, full, empty, eligible;
  flit_t                head [NumVc];
  logic                 load;
  logic                 grant_found;
  logic [VcBitSize-1:0] grant_vc, cand;

  staging_t             staging_q, staging_d;
  logic [VcBitSize-1:0] rr_q, rr_d;
  logic [CntW-1:0]      sent_q, sent_d;

  // One FIFO per VC; an out-of-range enq_vc matches no instance and is dropped.
  for (genvar v = 0; v < NumVc; v++) begin : g_vc
    assign push[v] = bus.enq_valid && (bus.enq_vc == VcBitSize'(v));

    inj_fifo #(
      .Depth (Depth)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (push[v]),
      .wdata_i (bus.enq_flit),
      .pop_i   (pop[v]),
      .rdata_o (head[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  // Pre-edge emptiness only: a flit enqueued this edge cannot be granted this edge.
  assign eligible = ~empty & bus.can_inject;
  assign load     = (bus.op == OpLoadStaging);

  // Round-robin search starting at rr_q; first eligible VC wins.
  always_comb begin
    grant_found = 1'b0;
    grant_vc    = rr_q;
    cand        = rr_q;
    for (int unsigned i = 0; i < NumVc; i++) begin
      cand = VcBitSize'((32'(rr_q) + i) % NumVc);
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_vc    = cand;
      end
    end
  end

  // Staging/pointer/counter next-state; the word lives for exactly one op.
  always_comb begin
    staging_d = '0;
    rr_d      = rr_q;
    sent_d    = sent_q;
    pop       = '0;
    if (load && grant_found) begin
      staging_d.full = 1'b1;
      staging_d.vc   = grant_vc;
      staging_d.flit = head[grant_vc];
      pop[grant_vc]  = 1'b1;
      rr_d           = VcBitSize'((32'(grant_vc) + 1) % NumVc);
      sent_d         = sent_q + CntW'(1);
    end
  end

  // Registered staging word, round-robin pointer and sent counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staging_q <= '0;
      rr_q      <= '0;
      sent_q    <= '0;
    end else begin
      staging_q <= staging_d;
      rr_q      <= rr_d;
      sent_q    <= sent_d;
    end
  end

  // Outputs derived from registered state only.
  always_comb begin
    bus.enq_ready   = ~full;
    bus.inj_staging = staging_q;
    bus.idle        = (&empty) && !staging_q.full;
    bus.flits_sent  = sent_q;
  end

endmodule

// File: doc/inject_unit.md
Name: inject_unit

Overview:
- Injection stage directly upstream of router local input port 0.
- Holds host/testbench flits in per-VC FIFOs.
- Drives the port-0 slice of the router's in_staging_pl bus, at most one flit per LoadStaging op.
- Honours the router's per-VC can_inject back-pressure.
- Reports idle, so the top level can combine it with router done to decide simulation end.

Parameters:
- NUM_VC, default `maxvc: number of virtual channels, each with its own FIFO.
- DEPTH, default 8: entries per VC FIFO (power of two, ≥2).
- CNT_W, default 32: width of the flits_sent counter.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- op, input, `op_size: router op bus, shared with the router.
- can_inject, input, NUM_VC: from router; bit v=1 means router buffer[0][v] is empty.
- enq_valid, input, 1: host offers a flit this cycle.
- enq_vc, input, `VcBitSize: target VC of the offered flit.
- enq_flit, input, `FlitBitSize: flit payload (dst, head, tail fields per parameters.v).
- enq_ready, output, NUM_VC: bit v=1 when FIFO v is not full.
- inj_staging, output, `BufferBitSize: port-0 staging word {`BufferFull, `BufferVc, `BufferFlit}.
- idle, output, 1: all FIFOs empty and inj_staging not full.
- flits_sent, output, CNT_W: total flits presented to the router since reset.

Behaviour:
- Reset (async, rst_n=0):
  - All FIFO pointers and counts cleared.
  - inj_staging=0, flits_sent=0, rr_ptr=0, idle=1.
  - enq_ready=all ones once out of reset.
  - Reset mid-operation discards queued flits; no partial output.
- Enqueue:
  - Accepted on posedge when enq_valid=1 and enq_ready[enq_vc]=1.
  - Flit written at tail of FIFO enq_vc.
  - enq_valid with FIFO full: flit ignored, no state change.
  - Out-of-range enq_vc (≥NUM_VC): ignored.
- Eligibility: VC v is eligible when FIFO v is non-empty before this edge's enqueue (no same-edge bypass) and can_inject[v]=1.
- Injection, on posedge where op==`LoadStaging:
  - Search v = rr_ptr, rr_ptr+1, … mod NUM_VC; the first eligible v wins.
  - Winner: inj_staging <= {1'b1, v, head flit of FIFO v}; pop FIFO v; rr_ptr <= (v+1) mod NUM_VC; flits_sent += 1, wrapping at 2^CNT_W.
  - No eligible VC: inj_staging <= 0; rr_ptr unchanged.
- Timing: the router samples in_staging_pl on the negedge of the same LoadStaging cycle. Latency from enqueue into an empty FIFO to a presented word is therefore ≥1 LoadStaging op after the enqueue edge.
- On posedge with any other op (NOP, Phase0, Phase1, LoadRt, Init), inj_staging <= 0. This guarantees no flit is double-loaded.
- Simultaneous pop and enqueue on the same VC at one edge:
  - Both take effect; count unchanged.
  - enq_ready is computed from pre-edge count, so a full FIFO rejects even while popping.
- Ordering:
  - Flits within a VC leave in FIFO order, so wormhole head..tail order is preserved per VC.
  - The unit does not check head/tail framing.
- Pointers: DEPTH-wrap binary pointers plus a count per VC, count range 0..DEPTH. Full when count==DEPTH; empty when count==0.
- op==`Init: FIFOs are NOT flushed; only rst_n clears state.
- idle is combinational from registered state.

Decomposition:
- Shared parameters.v (already present) supplies:
  - `BufferFull/`BufferVc/`BufferFlit field macros;
  - `FlitDst/`FlitHead/`FlitTail field macros;
  - op encodings;
  - width macros.
- Add to parameters.v: `InjDepth default and `InjCntBitSize.
- One sub-module, inj_fifo: single-VC synchronous FIFO with count, full, empty. Instantiated NUM_VC times via generate.
- Arbiter and staging register stay in the top.

Test Plan:
- Reset, then enqueue vc=1 flit (dst=12, head=1, tail=1); can_inject=4'b1111; op=LoadStaging → inj_staging={1,1,flit}, flits_sent=1; next op Phase0 → inj_staging=0, idle=1.
- 3 flits each queued on vc0 and vc2, can_inject all 1, six LoadStaging ops → grant order vc0,vc2,vc0,vc2,vc0,vc2; flits_sent=6.
- can_inject=4'b1110 with vc0 and vc1 non-empty, rr_ptr=0 → vc1 granted; vc0 head stays queued; raise can_inject[0] → vc0 granted next LoadStaging.
- Fill vc3 with DEPTH=8 flits → enq_ready[3]=0; 9th enq ignored; on one edge do LoadStaging pop plus enq to vc3 → enq rejected, count=7.
- Enqueue and LoadStaging on the same edge into empty vc0 → inj_staging=0; next LoadStaging → flit presented.
- Assert rst_n=0 mid-stream with 5 flits queued → outputs 0 immediately (async); after release idle=1, no flit ever presented.
